flow_update: RTL and testbench

FLOW_UPDATE -- requirements
Module: flow_update

---
 rtl/flow_update_pkg.sv | 17 +
 rtl/flow_word_update.sv | 39 +++
 rtl/flow_update.sv | 118 +++++++++++
 tb/tb_flow_update.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/flow_update_pkg.sv
// Shared traffic parameters and types for the flow-statistics update path.
// The pkt/byte counter widths must sum to no more than the flow-RAM word width.
package flow_update_pkg;

    localparam int FLOW_RAM_ADDR_WIDTH = 10;
    localparam int FLOW_RAM_WORD_WIDTH = 64;
    localparam int FLOW_PKT_CNT_WIDTH  = 8;
    localparam int FLOW_BYTE_CNT_WIDTH = 24;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } flow_state_e;

endpackage : flow_update_pkg

// File: rtl/flow_word_update.sv
// Combinational saturating update of one flow word: packet count +1 and
// byte count +pkt_size, both clamped at all-ones; upper bits pass through.
module flow_word_update
    import flow_update_pkg::*;
#(
    parameter int PKT_SIZE_WIDTH = 16
) (
    input  logic [FLOW_RAM_WORD_WIDTH-1:0] cur_word_i,
    input  logic [PKT_SIZE_WIDTH-1:0]      pkt_size_i,
    output logic [FLOW_RAM_WORD_WIDTH-1:0] new_word_o
);

    localparam int P     = FLOW_PKT_CNT_WIDTH;
    localparam int B     = FLOW_BYTE_CNT_WIDTH;
    localparam int SUM_W = ((PKT_SIZE_WIDTH > B) ? PKT_SIZE_WIDTH : B) + 1;

    logic [P-1:0]     pkt_cnt;
    logic [P-1:0]     pkt_cnt_nxt;
    logic [B-1:0]     byte_cnt;
    logic [B-1:0]     byte_cnt_nxt;
    logic [SUM_W-1:0] byte_sum;

    assign pkt_cnt  = cur_word_i[P-1:0];
    assign byte_cnt = cur_word_i[P+B-1:P];

    assign pkt_cnt_nxt = (&pkt_cnt) ? pkt_cnt : pkt_cnt + P'(1);

    // The sum is one bit wider than either operand, so any carry past the
    // byte field shows up in the top bits and forces saturation.
    assign byte_sum     = SUM_W'(byte_cnt) + SUM_W'(pkt_size_i);
    assign byte_cnt_nxt = (|byte_sum[SUM_W-1:B]) ? {B{1'b1}} : byte_sum[B-1:0];

    always_comb begin
        new_word_o              = cur_word_i;
        new_word_o[P-1:0]       = pkt_cnt_nxt;
        new_word_o[P+B-1:P]     = byte_cnt_nxt;
    end

endmodule : flow_word_update

// File: rtl/flow_update.sv
// Read-modify-write of per-flow packet/byte counters in an external flow RAM.
// One descriptor in flight at a time, so consecutive packets always see prior writes.
module flow_update
    import flow_update_pkg::*;
#(
    parameter int PKT_SIZE_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic                           pkt_valid,
    output logic                           pkt_ready,
    input  logic [FLOW_RAM_ADDR_WIDTH-1:0] pkt_flow_addr,
    input  logic [PKT_SIZE_WIDTH-1:0]      pkt_size,

    input  logic                           read_ready,
    output logic                           read_en,
    output logic [FLOW_RAM_ADDR_WIDTH-1:0] read_addr,
    input  logic [FLOW_RAM_WORD_WIDTH-1:0] read_data,
    input  logic                           read_data_new,

    input  logic                           write_ready,
    output logic                           write_en,
    output logic [FLOW_RAM_ADDR_WIDTH-1:0] write_addr,
    output logic [FLOW_RAM_WORD_WIDTH-1:0] write_data,

    output logic                           flow_out_valid,
    output logic [FLOW_RAM_WORD_WIDTH-1:0] flow_out_data
);

    flow_state_e                    state_q, state_d;
    logic [FLOW_RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PKT_SIZE_WIDTH-1:0]      size_q, size_d;
    logic [FLOW_RAM_WORD_WIDTH-1:0] word_q, word_d;
    logic [FLOW_RAM_WORD_WIDTH-1:0] upd_word;

    flow_word_update #(
        .PKT_SIZE_WIDTH(PKT_SIZE_WIDTH)
    ) u_word_update (
        .cur_word_i(read_data),
        .pkt_size_i(size_q),
        .new_word_o(upd_word)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            word_q  <= word_d;
        end
    end

    // NOTE: every output of this block is assigned a default first so no
    // path through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        word_d    = word_q;
        pkt_ready = 1'b0;
        read_en   = 1'b0;
        write_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    addr_d  = pkt_flow_addr;
                    size_d  = pkt_size;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                read_en = read_ready;
                if (read_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (read_data_new) begin
                    word_d  = upd_word;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                write_en = write_ready;
                if (write_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // NOTE: reset is synchronous, so the registers only clear at the next
        // edge; outputs are forced quiet combinationally for the whole time
        // reset is high, including the very first cycle.
        if (reset) begin
            pkt_ready = 1'b0;
            read_en   = 1'b0;
            write_en  = 1'b0;
        end
    end

    assign read_addr      = reset ? '0 : addr_q;
    assign write_addr     = reset ? '0 : addr_q;
    assign write_data     = reset ? '0 : word_q;
    assign flow_out_valid = write_en;
    assign flow_out_data  = write_data;

endmodule : flow_update

// File: tb/tb_flow_update.sv
// Directed bench for flow_update: a small flow-RAM model with read latency 1,
// hand-computed expected words, and ready back-pressure/reset scenarios.
module tb_flow_update;

    logic        clk = 1'b0;
    logic        reset;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [9:0]  pkt_flow_addr;
    logic [15:0] pkt_size;
    logic        read_ready;
    logic        read_en;
    logic [9:0]  read_addr;
    logic [63:0] read_data;
    logic        read_data_new;
    logic        write_ready;
    logic        write_en;
    logic [9:0]  write_addr;
    logic [63:0] write_data;
    logic        flow_out_valid;
    logic [63:0] flow_out_data;

    logic [63:0] mem [1024];
    int          vec_cnt = 0;
    int          err_cnt = 0;

    always #5 clk = ~clk;

    flow_update #(.PKT_SIZE_WIDTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .pkt_flow_addr  (pkt_flow_addr),
        .pkt_size       (pkt_size),
        .read_ready     (read_ready),
        .read_en        (read_en),
        .read_addr      (read_addr),
        .read_data      (read_data),
        .read_data_new  (read_data_new),
        .write_ready    (write_ready),
        .write_en       (write_en),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .flow_out_valid (flow_out_valid),
        .flow_out_data  (flow_out_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full descriptor: accept, read (optionally back-pressured), RAM
    // returns mem[a] one cycle later, write (optionally back-pressured).
    task automatic run_pkt(input logic [9:0] a, input logic [15:0] sz,
                           input logic [63:0] exp_word, input int rd_hold, input int wr_hold);
        int lat;
        check("idle_pkt_ready", 64'(pkt_ready), 64'd1);
        pkt_valid     = 1'b1;
        pkt_flow_addr = a;
        pkt_size      = sz;
        read_ready    = (rd_hold == 0);
        write_ready   = (wr_hold == 0);
        @(negedge clk);
        pkt_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < rd_hold; i++) begin
            check("rd_hold_read_en", 64'(read_en), 64'd0);
            check("rd_hold_pkt_ready", 64'(pkt_ready), 64'd0);
            read_data     = 64'hBAD0_BAD0_BAD0_BAD0;
            read_data_new = 1'b1;
            @(negedge clk);
            lat++;
        end
        read_data_new = 1'b0;
        read_ready    = 1'b1;
        #1;
        check("read_en", 64'(read_en), 64'd1);
        check("read_addr", 64'(read_addr), 64'(a));
        check("read_no_write", 64'(write_en), 64'd0);
        @(negedge clk);
        lat++;
        check("wait_read_en", 64'(read_en), 64'd0);
        read_data     = mem[a];
        read_data_new = 1'b1;
        @(negedge clk);
        lat++;
        read_data_new = 1'b0;
        read_data     = '0;
        for (int i = 0; i < wr_hold; i++) begin
            check("wr_hold_write_en", 64'(write_en), 64'd0);
            check("wr_hold_out_valid", 64'(flow_out_valid), 64'd0);
            check("wr_hold_read_en", 64'(read_en), 64'd0);
            @(negedge clk);
            lat++;
        end
        write_ready = 1'b1;
        #1;
        check("write_en", 64'(write_en), 64'd1);
        check("write_addr", 64'(write_addr), 64'(a));
        check("write_data", write_data, exp_word);
        check("out_valid", 64'(flow_out_valid), 64'd1);
        check("out_data", flow_out_data, exp_word);
        check("write_no_read", 64'(read_en), 64'd0);
        if (rd_hold == 0 && wr_hold == 0) begin
            check("accept_to_write_latency", 64'(lat), 64'd3);
        end
        mem[a] = exp_word;
        @(negedge clk);
        check("next_pkt_ready", 64'(pkt_ready), 64'd1);
        check("post_write_en", 64'(write_en), 64'd0);
        check("post_out_valid", 64'(flow_out_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[5]  = 64'hDEAD_BEEF_FFFF_00FF;
        mem[7]  = 64'h0123_4567_0000_1003;
        mem[9]  = 64'h0000_0000_FFFF_9CFE;

        reset         = 1'b1;
        pkt_valid     = 1'b0;
        pkt_flow_addr = '0;
        pkt_size      = '0;
        read_ready    = 1'b1;
        read_data     = '0;
        read_data_new = 1'b0;
        write_ready   = 1'b1;

        @(negedge clk);
        @(negedge clk);
        check("rst_pkt_ready", 64'(pkt_ready), 64'd0);
        check("rst_read_en", 64'(read_en), 64'd0);
        check("rst_write_en", 64'(write_en), 64'd0);
        check("rst_out_valid", 64'(flow_out_valid), 64'd0);
        check("rst_write_data", write_data, 64'd0);
        check("rst_write_addr", 64'(write_addr), 64'd0);
        reset = 1'b0;
        #1;
        check("first_cycle_pkt_ready", 64'(pkt_ready), 64'd1);
        @(negedge clk);

        // Fresh flow, then a second packet to the same flow.
        run_pkt(10'd12, 16'd100, 64'h0000_0000_0000_6401, 0, 0);
        run_pkt(10'd12, 16'd60,  64'h0000_0000_0000_A002, 0, 0);
        // Both counters saturate; upper bits untouched.
        run_pkt(10'd5, 16'd1000, 64'hDEAD_BEEF_FFFF_FFFF, 0, 0);
        // Counters land exactly on all-ones without overflow.
        run_pkt(10'd9, 16'd99, 64'h0000_0000_FFFF_FFFF, 0, 0);
        // Read and write back-pressure of 5 cycles each, stray read data ignored.
        run_pkt(10'd7, 16'h0020, 64'h0123_4567_0000_3004, 5, 5);
        // All-ones address with the largest packet size.
        run_pkt(10'h3FF, 16'hFFFF, 64'h0000_0000_00FF_FF01, 0, 0);

        // Reset while waiting for read data abandons the transaction.
        pkt_valid     = 1'b1;
        pkt_flow_addr = 10'd20;
        pkt_size      = 16'd50;
        read_ready    = 1'b1;
        write_ready   = 1'b1;
        @(negedge clk);
        pkt_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_pkt_ready", 64'(pkt_ready), 64'd0);
        check("midrst_read_en", 64'(read_en), 64'd0);
        check("midrst_read_addr", 64'(read_addr), 64'd0);
        @(negedge clk);
        check("midrst_write_en", 64'(write_en), 64'd0);
        check("midrst_out_data", flow_out_data, 64'd0);
        reset         = 1'b0;
        read_data     = 64'h0000_0000_0000_1234;
        read_data_new = 1'b1;
        #1;
        check("midrst_ready_after", 64'(pkt_ready), 64'd1);
        @(negedge clk);
        read_data_new = 1'b0;
        check("late_data_write_en", 64'(write_en), 64'd0);
        check("late_data_out_valid", 64'(flow_out_valid), 64'd0);
        check("late_data_pkt_ready", 64'(pkt_ready), 64'd1);

        // Flow 20 was never written, so a new packet starts from zero.
        run_pkt(10'd20, 16'd7, 64'h0000_0000_0000_0701, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_flow_update
